alu_iter_exec: RTL and testbench

- Execute-side consumer of the 4-bit ALUControl code produced by the ALU decoder.
- Accepts operands plus ALUControl over a valid/ready handshake.
- Single-cycle logic/arith ops complete in one cycle; shifts use an iterative 1-bit/cycle shifter (area-reduced core variant).
- Result is returned on a valid/ready output channel to the writeback stage.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_serial_shifter.sv | 56 +++++
 rtl/alu_iter_exec.sv | 148 ++++++++++++++
 tb/tb_alu_iter_exec.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: decoder ALUControl codes, execute-unit states and op-class helpers.
// The decoder imports the same code constants, so both sides stay in lockstep.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic is_shift(input logic [3:0] code);
      return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
   endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Iterative 1-bit-per-cycle shifter: loads an operand and a count, then shifts until the count drains.
// 'value' is the register after one more step, so the owner can capture the final result on the last step.
module alu_serial_shifter
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic             dir,
   input  logic             arith,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] data,
   output logic             done,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] r_value;
   logic [SHW-1:0]   r_count;
   logic             r_dir;
   logic             r_arith;
   logic [WIDTH-1:0] w_step;

   // dir=1 shifts right; arith selects MSB replication instead of zero fill
   always_comb begin
      w_step = {r_value[WIDTH-2:0], 1'b0};
      if (r_dir) begin
         w_step = {r_arith & r_value[WIDTH-1], r_value[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_value <= '0;
         r_count <= '0;
         r_dir   <= 1'b0;
         r_arith <= 1'b0;
      end else if (clear) begin
         r_count <= '0;
      end else if (load) begin
         r_value <= data;
         r_count <= shamt;
         r_dir   <= dir;
         r_arith <= arith;
      end else if (r_count != '0) begin
         r_value <= w_step;
         r_count <= r_count - SHW'(1);
      end
   end

   assign done  = (r_count == SHW'(1));
   assign value = w_step;

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, serial shifts, valid/ready on both sides.
// A held result in DONE can be retired and replaced by a new request in the same cycle.
module alu_iter_exec
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_stateNext;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_illegal;

   logic             w_accept;
   logic [SHW-1:0]   w_shamt;
   logic             w_goShift;
   logic [WIDTH-1:0] w_aluResult;
   logic             w_aluIllegal;
   logic             w_shDone;
   logic [WIDTH-1:0] w_shValue;
   logic             w_shDir;
   logic             w_shArith;

   assign in_ready  = !flush && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
   assign w_accept  = in_valid && in_ready;
   assign w_shamt   = src_b[SHW-1:0];
   assign w_goShift = is_shift(alu_control) && (w_shamt != '0);
   assign w_shDir   = (alu_control != ALU_SLL);
   assign w_shArith = (alu_control == ALU_SRA);

   // Shift codes fall through as src_a: that is the shift-by-zero answer
   always_comb begin
      w_aluResult  = '0;
      w_aluIllegal = 1'b0;
      case (alu_control)
         ALU_ADD:  w_aluResult = src_a + src_b;
         ALU_SUB:  w_aluResult = src_a - src_b;
         ALU_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         ALU_XOR:  w_aluResult = src_a ^ src_b;
         ALU_OR:   w_aluResult = src_a | src_b;
         ALU_AND:  w_aluResult = src_a & src_b;
         ALU_SLL,
         ALU_SRL,
         ALU_SRA:  w_aluResult = src_a;
         default:  w_aluIllegal = 1'b1;
      endcase
   end

   always_comb begin
      w_stateNext = r_state;
      if (flush) begin
         w_stateNext = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  w_stateNext = w_goShift ? ST_SHIFT : ST_DONE;
               end
            end
            ST_SHIFT: begin
               if (w_shDone) begin
                  w_stateNext = ST_DONE;
               end
            end
            ST_DONE: begin
               if (w_accept) begin
                  w_stateNext = w_goShift ? ST_SHIFT : ST_DONE;
               end else if (out_ready) begin
                  w_stateNext = ST_IDLE;
               end
            end
            default: w_stateNext = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Result registers change only on accept or final shift step, so they hold under backpressure
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
      end else if (flush) begin
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
      end else if (w_accept && !w_goShift) begin
         r_result  <= w_aluResult;
         r_zero    <= (w_aluResult == '0);
         r_illegal <= w_aluIllegal;
      end else if (w_accept) begin
         r_illegal <= 1'b0;
      end else if ((r_state == ST_SHIFT) && w_shDone) begin
         r_result  <= w_shValue;
         r_zero    <= (w_shValue == '0);
      end
   end

   alu_serial_shifter #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_shifter (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (flush),
      .load    (w_accept && w_goShift),
      .dir     (w_shDir),
      .arith   (w_shArith),
      .shamt   (w_shamt),
      .data    (src_a),
      .done    (w_shDone),
      .value   (w_shValue)
   );

   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign result    = r_result;
   assign zero      = r_zero;
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec: expected results are queued at issue and popped when the unit delivers.
// Shift latency is counted as the number of cycles spent between accept and out_valid.
module tb_alu_iter_exec;

   logic        clk;
   logic        resetN;
   logic        inValid;
   logic        inReady;
   logic [3:0]  aluControl;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        flush;
   logic        outValid;
   logic        outReady;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
   logic        busy;

   typedef struct packed {
      logic [31:0] result;
      logic        zero;
      logic        illegal;
   } exp_t;

   exp_t sbQ[$];
   int   checks = 0;
   int   errors = 0;

   alu_iter_exec #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (resetN),
      .in_valid    (inValid),
      .in_ready    (inReady),
      .alu_control (aluControl),
      .src_a       (srcA),
      .src_b       (srcB),
      .flush       (flush),
      .out_valid   (outValid),
      .out_ready   (outReady),
      .result      (result),
      .zero        (zero),
      .illegal     (illegal),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
      end
   endtask

   task automatic pushExp(input logic [31:0] r, input logic z, input logic i);
      exp_t e;
      e.result  = r;
      e.zero    = z;
      e.illegal = i;
      sbQ.push_back(e);
   endtask

   task automatic popCompare(input string tag);
      exp_t e;
      check({tag, " pending"}, 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
         e = sbQ.pop_front();
         check({tag, " result"},  result,  e.result);
         check({tag, " zero"},    32'(zero),    32'(e.zero));
         check({tag, " illegal"}, 32'(illegal), 32'(e.illegal));
      end
   endtask

   // Drives one request and returns just after the accepting edge
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input bit track, input logic [31:0] r, input logic z, input logic i);
      int n = 0;
      while (!inReady && n < 100) begin
         tick();
         n++;
      end
      check("issue ready", 32'(inReady), 32'd1);
      aluControl = op;
      srcA       = a;
      srcB       = b;
      inValid    = 1'b1;
      if (track) pushExp(r, z, i);
      tick();
      inValid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input int expShift);
      int lat = 1;
      outReady = 1'b1;
      while (!outValid && lat < 100) begin
         tick();
         lat++;
      end
      check({tag, " shift cycles"}, 32'(lat - 1), 32'(expShift));
      popCompare(tag);
      tick();
   endtask

   initial begin
      bit sawValid;
      resetN     = 1'b0;
      inValid    = 1'b0;
      aluControl = 4'b0000;
      srcA       = '0;
      srcB       = '0;
      flush      = 1'b0;
      outReady   = 1'b1;
      $display("[TB] reset");
      tick();
      tick();
      check("rst out_valid", 32'(outValid), 32'd0);
      check("rst result",    result,        32'd0);
      check("rst zero",      32'(zero),     32'd1);
      check("rst illegal",   32'(illegal),  32'd0);
      check("rst busy",      32'(busy),     32'd0);
      resetN = 1'b1;
      #1;
      check("rst in_ready", 32'(inReady), 32'd1);

      $display("[TB] arithmetic and compare");
      applyStimulus(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
      checkOutput("add", 0);
      applyStimulus(4'b1000, 32'd5, 32'd5, 1'b1, 32'd0, 1'b1, 1'b0);
      checkOutput("sub", 0);
      applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd1, 1'b0, 1'b0);
      checkOutput("slt", 0);
      applyStimulus(4'b0011, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0);
      checkOutput("sltu", 0);

      $display("[TB] shifts");
      applyStimulus(4'b1101, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, 1'b0, 1'b0);
      checkOutput("sra4", 4);
      applyStimulus(4'b0101, 32'h8000_0000, 32'd4, 1'b1, 32'h0800_0000, 1'b0, 1'b0);
      checkOutput("srl4", 4);
      applyStimulus(4'b0001, 32'h0000_0001, 32'd31, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
      checkOutput("sll31", 31);
      applyStimulus(4'b0001, 32'h1234_5678, 32'h0000_0020, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
      checkOutput("sll0", 0);

      $display("[TB] backpressure and back-to-back");
      outReady = 1'b0;
      applyStimulus(4'b0110, 32'h0000_00A5, 32'h0000_5A00, 1'b1, 32'h0000_5AA5, 1'b0, 1'b0);
      check("bp out_valid", 32'(outValid), 32'd1);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp hold result", result, 32'h0000_5AA5);
         check("bp hold in_ready", 32'(inReady), 32'd0);
      end
      aluControl = 4'b0100;
      srcA       = 32'h0000_F0F0;
      srcB       = 32'h0000_0FF0;
      inValid    = 1'b1;
      outReady   = 1'b1;
      #1;
      check("b2b in_ready", 32'(inReady), 32'd1);
      popCompare("or held");
      pushExp(32'h0000_FF00, 1'b0, 1'b0);
      tick();
      inValid = 1'b0;
      checkOutput("xor b2b", 0);

      $display("[TB] flush");
      applyStimulus(4'b0001, 32'h0000_0001, 32'd10, 1'b0, 32'd0, 1'b0, 1'b0);
      tick();
      flush      = 1'b1;
      aluControl = 4'b0000;
      srcA       = 32'd9;
      srcB       = 32'd9;
      inValid    = 1'b1;
      #1;
      check("flush in_ready", 32'(inReady), 32'd0);
      tick();
      flush   = 1'b0;
      inValid = 1'b0;
      check("flush busy", 32'(busy), 32'd0);
      sawValid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (outValid) sawValid = 1'b1;
         tick();
      end
      check("flush no out_valid", 32'(sawValid), 32'd0);
      applyStimulus(4'b0000, 32'd3, 32'd4, 1'b1, 32'd7, 1'b0, 1'b0);
      checkOutput("add after flush", 0);

      $display("[TB] reset mid-shift");
      applyStimulus(4'b0001, 32'h0000_0001, 32'd20, 1'b0, 32'd0, 1'b0, 1'b0);
      tick();
      tick();
      resetN = 1'b0;
      #1;
      check("mid rst out_valid", 32'(outValid), 32'd0);
      check("mid rst busy",      32'(busy),     32'd0);
      check("mid rst result",    result,        32'd0);
      check("mid rst zero",      32'(zero),     32'd1);
      check("mid rst illegal",   32'(illegal),  32'd0);
      tick();
      resetN = 1'b1;
      sawValid = 1'b0;
      for (int k = 0; k < 25; k++) begin
         if (outValid) sawValid = 1'b1;
         tick();
      end
      check("post rst no out_valid", 32'(sawValid), 32'd0);

      $display("[TB] illegal code");
      applyStimulus(4'b1111, 32'h1111_1111, 32'h2222_2222, 1'b1, 32'd0, 1'b1, 1'b1);
      checkOutput("illegal", 0);
      applyStimulus(4'b0111, 32'h0000_00FF, 32'h0000_000F, 1'b1, 32'h0000_000F, 1'b0, 1'b0);
      checkOutput("and after illegal", 0);

      check("scoreboard drained", 32'(sbQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
